// File: rtl/adder_scan_display.sv
// Button-entered hex operands, registered add/sub with carry and signed overflow,
// and a multiplexed digit scanner feeding a downstream hex-to-segment decoder.
module adder_scan_display #(
  parameter int NIB      = 2,
  parameter int SCAN_DIV = 17,
  parameter int DB_CYC   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*NIB-1:0] btn,
  input  logic             mode,
  input  logic             clr,
  input  logic [3*NIB:0]   le_sw,
  input  logic [3*NIB:0]   dp_sw,
  output logic [3*NIB:0]   an,
  output logic [3:0]       digit,
  output logic             le,
  output logic             point,
  output logic [4*NIB-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int W    = 4 * NIB;
  localparam int NDIG = 3 * NIB + 1;
  localparam int NBTN = 2 * NIB;
  localparam int DBW  = $clog2(DB_CYC + 1);
  localparam int IDXW = $clog2(NDIG);

  localparam logic [DBW-1:0]      DB_LAST  = DBW'(DB_CYC - 1);
  localparam logic [IDXW-1:0]     IDX_LAST = IDXW'(NDIG - 1);
  localparam logic [SCAN_DIV-1:0] SCAN_ONE = SCAN_DIV'(1);

  logic [NBTN-1:0]     meta_q, sync_q;
  logic [NBTN-1:0]     deb_q, deb_d;
  logic [NBTN-1:0]     deb_prev_q;
  logic [DBW-1:0]      db_cnt_q [NBTN];
  logic [DBW-1:0]      db_cnt_d [NBTN];
  logic [NBTN-1:0]     rise;

  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [W-1:0]        b_eff;
  logic [W:0]          sum;
  logic [W-1:0]        result_q, result_d;
  logic                cout_q, cout_d, ovf_q, ovf_d;

  logic [SCAN_DIV-1:0] scan_q, scan_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic [3:0]          digit_q, digit_d;
  logic                le_q, le_d, point_q, point_d;

  // A level change is accepted only after DB_CYC consecutive differing samples.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        deb_d[i]    = sync_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  // Nibbles wrap independently; clear wins over any same-cycle increment.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int n = 0; n < NIB; n++) begin
      if (rise[n])       a_d[4*n +: 4] = a_q[4*n +: 4] + 4'd1;
      if (rise[NIB + n]) b_d[4*n +: 4] = b_q[4*n +: 4] + 4'd1;
    end
    if (clr) begin
      a_d = '0;
      b_d = '0;
    end
  end

  always_comb begin
    b_eff    = mode ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, b_eff} + {{W{1'b0}}, mode};
    result_d = sum[W-1:0];
    cout_d   = sum[W];
    ovf_d    = (a_q[W-1] == b_eff[W-1]) && (sum[W-1] != a_q[W-1]);
  end

  always_comb begin
    scan_d = scan_q + SCAN_ONE;
    idx_d  = idx_q;
    if (&scan_q) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
    end
  end

  // Display fields are registered together from idx so an/digit/le/point stay aligned.
  always_comb begin
    an_d    = ~(NDIG'(1) << idx_q);
    le_d    = le_sw[idx_q];
    point_d = dp_sw[idx_q];
    digit_d = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDXW'(n))           digit_d = a_q[4*n +: 4];
      if (idx_q == IDXW'(NIB + n))     digit_d = b_q[4*n +: 4];
      if (idx_q == IDXW'(2 * NIB + n)) digit_d = result_q[4*n +: 4];
    end
    if (idx_q == IDXW'(3 * NIB)) digit_d = {3'b000, cout_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      an_q       <= ~NDIG'(1);
      digit_q    <= 4'h0;
      le_q       <= 1'b0;
      point_q    <= 1'b0;
    end else begin
      meta_q     <= btn;
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
      le_q       <= le_d;
      point_q    <= point_d;
    end
  end

  assign an     = an_q;
  assign digit  = digit_q;
  assign le     = le_q;
  assign point  = point_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_adder_scan_display.sv
// Directed bench: a 1-nibble instance for buttons, clear, scan and reset, and a
// 2-nibble instance for add/sub flag cases.
module tb_adder_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [1:0] btn1 = '0;
  logic       mode1 = 1'b0, clr1 = 1'b0;
  logic [3:0] le_sw1 = 4'b1000, dp_sw1 = 4'b0100;
  logic [3:0] an1, digit1, result1;
  logic       le1, point1, cout1, ovf1;

  logic [3:0] btn2 = '0;
  logic       mode2 = 1'b0, clr2 = 1'b0;
  logic [6:0] le_sw2 = '0, dp_sw2 = '0;
  logic [6:0] an2;
  logic [3:0] digit2;
  logic [7:0] result2;
  logic       le2, point2, cout2, ovf2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adder_scan_display #(.NIB(1), .SCAN_DIV(2), .DB_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst), .btn(btn1), .mode(mode1), .clr(clr1),
    .le_sw(le_sw1), .dp_sw(dp_sw1), .an(an1), .digit(digit1), .le(le1),
    .point(point1), .result(result1), .cout(cout1), .ovf(ovf1)
  );

  adder_scan_display #(.NIB(2), .SCAN_DIV(2), .DB_CYC(4)) u_dut2 (
    .clk(clk), .rst(rst), .btn(btn2), .mode(mode2), .clr(clr2),
    .le_sw(le_sw2), .dp_sw(dp_sw2), .an(an2), .digit(digit2), .le(le2),
    .point(point2), .result(result2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit on2, input logic [3:0] mask);
    if (on2) btn2 = mask;
    else     btn1 = mask[1:0];
    step(12);
    btn1 = '0;
    btn2 = '0;
    step(12);
  endtask

  logic [3:0] exp_an [4];
  logic [3:0] exp_dig [4];
  logic [3:0] prev_an;
  bit         found;

  initial begin
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_dig = '{4'h3, 4'h5, 4'h8, 4'h0};

    step(2);
    check("rst_an1", an1, 4'b1110);
    check("rst_digit1", digit1, 0);
    check("rst_result1", result1, 0);
    check("rst_cout1", cout1, 0);
    check("rst_point1", point1, 0);
    check("rst_an2", an2, 7'b1111110);
    @(negedge clk) rst = 1'b0;
    step(1);

    // A=0x7F, B=0x01 on the two-nibble instance
    press(1'b1, 4'b0111);
    for (int i = 0; i < 6; i++) press(1'b1, 4'b0011);
    for (int i = 0; i < 8; i++) press(1'b1, 4'b0001);
    mode2 = 1'b0; step(2);
    check("add_res", result2, 8'h80);
    check("add_cout", cout2, 0);
    check("add_ovf", ovf2, 1);
    mode2 = 1'b1; step(2);
    check("sub_res", result2, 8'h7E);
    check("sub_cout", cout2, 1);
    check("sub_ovf", ovf2, 0);
    clr2 = 1'b1; step(1); clr2 = 1'b0;
    press(1'b1, 4'b0100);
    check("neg_res", result2, 8'hFF);
    check("neg_cout", cout2, 0);
    check("neg_ovf", ovf2, 0);

    // Button latency: increment lands 6 edges after first sample
    btn1 = 2'b01;
    step(7);
    check("lat_early", result1, 0);
    step(1);
    check("lat_hit", result1, 1);
    step(12);
    btn1 = '0;
    step(12);
    for (int i = 0; i < 3; i++) press(1'b0, 4'b0001);
    check("inc_res", result1, 4);
    check("inc_cout", cout1, 0);

    btn1 = 2'b10; step(3); btn1 = '0; step(15);
    check("glitch", result1, 4);
    for (int i = 0; i < 17; i++) press(1'b0, 4'b0010);
    check("wrap_add", result1, 5);
    mode1 = 1'b1; step(2);
    check("wrap_sub", result1, 3);
    check("wrap_sub_cout", cout1, 1);
    mode1 = 1'b0; step(2);

    // Clear on the same edge as a debounced rising edge
    btn1 = 2'b01;
    step(6);
    clr1 = 1'b1;
    step(1);
    clr1 = 1'b0;
    check("clr_lag", result1, 5);
    step(1);
    check("clr_res", result1, 0);
    step(10);
    check("clr_noinc", result1, 0);
    btn1 = '0;
    step(12);
    mode1 = 1'b1; step(2);
    check("clr_sub_res", result1, 0);
    check("clr_sub_cout", cout1, 1);
    mode1 = 1'b0; step(2);

    for (int i = 0; i < 3; i++) press(1'b0, 4'b0011);
    for (int i = 0; i < 2; i++) press(1'b0, 4'b0010);
    check("scan_pre", result1, 8);

    found = 1'b0;
    prev_an = an1;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (an1 == 4'hE && prev_an != 4'hE) found = 1'b1;
      prev_an = an1;
    end
    check("scan_sync", found, 1);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("scan_an%0d", d), an1, exp_an[d]);
        check($sformatf("scan_dig%0d", d), digit1, exp_dig[d]);
        check($sformatf("scan_dp%0d", d), point1, (d == 2) ? 1 : 0);
        check($sformatf("scan_le%0d", d), le1, (d == 3) ? 1 : 0);
        step(4);
      end
    end

    // Reset mid-debounce with A=9
    for (int i = 0; i < 6; i++) press(1'b0, 4'b0001);
    check("rm_pre", result1, 14);
    btn1 = 2'b01;
    step(3);
    #2 rst = 1'b1;
    #1;
    check("rm_result", result1, 0);
    check("rm_an", an1, 4'b1110);
    check("rm_digit", digit1, 0);
    check("rm_cout", cout1, 0);
    check("rm_le", le1, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    step(6);
    check("rm_early", result1, 0);
    step(1);
    check("rm_inc", result1, 1);
    btn1 = '0;
    step(12);
    check("rm_once", result1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
